// File: rtl/shift_register_bank.sv
// ---------------------------------------------------------------------------
// shift_register_bank
//   A bank of NUM_REGS registers, each WIDTH bits wide, for the qtcore
//   datapath. Any one register can be loaded, shifted left, shifted right or
//   rotated left by an addressed functional write. Two independent read
//   ports give combinational access to the bank. All registers are also
//   linked into one serial scan chain. A bit counter tracks progress through
//   each full pass of the chain and pulses when a pass completes.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_we           functional op enable for register i_waddr
//   i_waddr        target register of the functional op
//   i_op           00 LOAD, 01 SHL, 10 SHR, 11 ROTL
//   i_wdata        load data; bit 0 is also the SHL fill bit
//   i_raddr_a      read port A address
//   o_rdata_a      read port A data (combinational, 0 when out of range)
//   i_raddr_b      read port B address
//   o_rdata_b      read port B data (combinational, 0 when out of range)
//   i_scan_enable  shift the whole chain by one bit
//   i_scan_in      serial input into reg[0] bit 0
//   o_scan_out     serial output, MSB of the last register
//   o_scan_count   bits shifted in the current pass, 0..CHAIN_LEN-1
//   o_scan_done    one-cycle pulse after the last shift of a pass
// ---------------------------------------------------------------------------
module shift_register_bank #(
  parameter  int WIDTH     = 8,
  parameter  int NUM_REGS  = 4,
  localparam int ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CHAIN_LEN = NUM_REGS * WIDTH,
  localparam int CNT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [1:0]        i_op,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [WIDTH-1:0]  o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  o_rdata_b,
  input  logic              i_scan_enable,
  input  logic              i_scan_in,
  output logic              o_scan_out,
  output logic [CNT_W-1:0]  o_scan_count,
  output logic              o_scan_done
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CHAIN_LEN - 1);

  logic [WIDTH-1:0]     r_regs      [NUM_REGS];
  logic [CNT_W-1:0]     r_scanCount;
  logic                 r_scanDone;

  logic [WIDTH-1:0]     w_regsNext  [NUM_REGS];
  logic [CHAIN_LEN-1:0] w_chain;
  logic [CHAIN_LEN-1:0] w_chainShifted;
  logic                 w_shiftDo;

  // Functional op result for one register. The shift-based forms stay
  // valid when WIDTH is 1: SHL then yields the fill bit, SHR yields 0 and
  // ROTL leaves the bit unchanged, with no out-of-range part selects.
  function automatic logic [WIDTH-1:0] applyOp(
    input op_t              op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] data
  );
    logic [WIDTH-1:0] result;
    case (op)
      OP_LOAD: result = data;
      OP_SHL:  result = (cur << 1) | WIDTH'(data[0]);
      OP_SHR:  result = cur >> 1;
      OP_ROTL: result = (cur << 1) | (cur >> (WIDTH - 1));
      default: result = cur;
    endcase
    return result;
  endfunction

  // Flatten the bank into one chain vector with reg[0] at the LSB end, so
  // a single left shift moves every bit one step toward o_scan_out and
  // carries each register's MSB into the next register's LSB.
  always_comb begin
    w_chain = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_chain[i*WIDTH +: WIDTH] = r_regs[i];
    end
    w_chainShifted = (w_chain << 1) | CHAIN_LEN'(i_scan_in);
  end

  // Next-state selection with a strict priority: a functional write wins
  // over a scan shift, and an out-of-range write address still blocks the
  // shift even though no register matches it.
  always_comb begin
    w_shiftDo = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_regsNext[i] = r_regs[i];
    end
    if (i_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_waddr == ADDR_W'(i)) begin
          w_regsNext[i] = applyOp(op_t'(i_op), r_regs[i], i_wdata);
        end
      end
    end else if (i_scan_enable) begin
      w_shiftDo = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        w_regsNext[i] = w_chainShifted[i*WIDTH +: WIDTH];
      end
    end
  end

  // State registers. The pass counter only moves on a performed shift and
  // the done flag records that the shift just taken wrapped the counter,
  // so it is high for exactly the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_scanCount <= '0;
      r_scanDone  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_regsNext[i];
      end
      r_scanDone <= w_shiftDo && (r_scanCount == LAST_COUNT);
      if (w_shiftDo) begin
        r_scanCount <= (r_scanCount == LAST_COUNT) ? '0
                                                   : r_scanCount + CNT_W'(1);
      end
    end
  end

  // Read ports are a plain address decode with no write bypass; an address
  // that matches no register falls through to zero.
  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_raddr_a == ADDR_W'(i)) begin
        o_rdata_a = r_regs[i];
      end
      if (i_raddr_b == ADDR_W'(i)) begin
        o_rdata_b = r_regs[i];
      end
    end
  end

  assign o_scan_out   = r_regs[NUM_REGS-1][WIDTH-1];
  assign o_scan_count = r_scanCount;
  assign o_scan_done  = r_scanDone;

endmodule
